uart_transceiver: RTL and testbench
===================================

Name: uart_transceiver

Overview:
- Full-duplex 8N1 UART block: an independent transmitter and receiver sharing one clock, each with a level-based go/acknowledge handshake.
- Sits between the memory-mapped I/O bridge and the board uart_tx/uart_rx pins. The bridge writes bytes to send and collects received bytes.
- Transmitter and receiver never interact.

Parameters:
- CLK_FREQ, 50_000_000: clk frequency in Hz.
- BAUD_RATE, 9600: line rate in bits/s. Bit period BIT_TICKS = CLK_FREQ / BAUD_RATE (integer division), in clk cycles.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-low (block in reset while rst=0).
- tx_data  in  8  byte to transmit; sampled when a transmission starts.
- tx_go  in  1  high starts transmission; driver lowers it after tx_bsy falls, to acknowledge.
- tx  out  1  serial output line, idle high.
- tx_bsy  out  1  high while a frame is being sent.
- rx  in  1  serial input line, asynchronous to clk.
- rx_go  in  1  high enables reception; driver lowers it to acknowledge rx_dr.
- rx_data  out  8  received byte; valid only while rx_dr=1.
- rx_dr  out  1  data ready: a complete, valid frame is held in rx_data.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - tx=1, tx_bsy=0, rx_dr=0, rx_data=0;
  - both FSMs to IDLE, all counters cleared, the rx synchronizer to all-ones.
- Reset asserted mid-frame aborts the frame immediately; tx returns high.
- Frame format: one start bit (0), 8 data bits LSB first, one stop bit (1), each BIT_TICKS cycles.

Transmitter FSM (IDLE -> START -> DATA -> STOP -> ACK):
- IDLE: tx=1, tx_bsy=0. When tx_go=1 is sampled:
  - latch tx_data into the shift register;
  - set tx_bsy=1 on the next cycle;
  - go to START.
- START: tx=0 for BIT_TICKS cycles.
- DATA: shift out bits 0..7, each BIT_TICKS cycles.
- STOP: tx=1 for BIT_TICKS cycles.
- Leaving STOP clears tx_bsy.
- ACK: tx=1, tx_bsy=0. Remain in ACK while tx_go=1; go to IDLE once tx_go=0. This guarantees one frame per tx_go pulse.
- tx_bsy rises exactly 1 cycle after tx_go is first sampled high.
- Total time with tx_bsy=1 is exactly 10*BIT_TICKS cycles.
- Changing tx_data while tx_bsy=1 has no effect on the frame in progress.

Receiver FSM (IDLE -> START -> DATA -> STOP -> READY):
- rx is passed through a 2-flop synchronizer; all decisions use the synchronized value.
- IDLE: wait while rx_go=0. With rx_go=1, a synchronized rx=0 enters START.
- START: wait BIT_TICKS/2 cycles, then sample.
  - If rx=1 (glitch), return to IDLE.
  - Otherwise go to DATA.
- DATA: sample every BIT_TICKS cycles at mid-bit, shifting into rx_data LSB first. rx_data may change during reception.
- STOP: sample after BIT_TICKS cycles.
  - If rx=1: set rx_dr=1 and go to READY.
  - If rx=0 (framing error): discard the frame, keep rx_dr=0, and go to IDLE only after rx has returned high.
- READY: rx_dr=1 and rx_data held stable. When rx_go=0 is sampled, clear rx_dr on the next cycle and go to IDLE.
- Bytes arriving while in READY or while rx_go=0 are dropped (no overrun buffering).
- Lowering rx_go mid-frame does not abort the frame. The frame completes, then the acknowledge is honoured in READY.

Simultaneous events:
- TX and RX operate concurrently with no interference, including full-duplex loopback with tx wired to rx.

Timing:
- rx_dr rises about 9.5*BIT_TICKS + 3 cycles after the start-bit falling edge: the mid-stop sample plus synchronizer delay.
- A bench must accept ±2 cycles of tolerance on this.

Test Plan:
- CLK_FREQ=1000, BAUD_RATE=100 (BIT_TICKS=10):
  - Stimulus: pulse tx_go with tx_data=0xA5.
  - Response: tx_bsy high 1 cycle later for exactly 100 cycles; tx line shows 0, 1,0,1,0,0,1,0,1, 1, each held 10 cycles.
  - Continued: hold tx_go high after tx_bsy falls. Response: no second frame starts; lowering tx_go then re-raising it sends a new frame.
- rx_go=1; drive frame 0x3C on rx at 10 cycles/bit:
  - Response: rx_dr=1 with rx_data=0x3C.
  - Continued: drop rx_go for 1 cycle. Response: rx_dr=0 next cycle.
  - Continued: second frame 0xFF. Response: rx_data=0xFF.
- Drive a 3-cycle low glitch on idle rx:
  - Response: no rx_dr, receiver back in IDLE, and a following valid frame 0x55 is received correctly.
- Drive a frame whose stop bit is 0:
  - Response: rx_dr stays 0.
  - Continued: after rx returns high, the next frame 0x81 is received.
- Loopback, tx wired to rx:
  - Stimulus: send 0x00, 0xFF, 0x7E back-to-back via the handshake.
  - Response: each received in order with rx_dr.
  - Continued: rx_go held low during a frame. Response: that byte is dropped.
- Assert rst=0 mid-transmit and mid-receive:
  - Response: tx=1, tx_bsy=0, rx_dr=0, rx_data=0 immediately, without waiting for a clock edge.
  - Continued: normal operation after release.

Source files
------------

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent transmitter and receiver, each with a
// level-based go/acknowledge handshake toward the I/O bridge.
module uart_transceiver #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_go,
  output logic       tx,
  output logic       tx_bsy,
  input  logic       rx,
  input  logic       rx_go,
  output logic [7:0] rx_data,
  output logic       rx_dr
);

  localparam int BIT_TICKS  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int CW         = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_TICKS - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_ACK} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_FERR, RX_READY} rx_state_t;

  tx_state_t     tx_state, tx_state_nx;
  logic [CW-1:0] tx_cnt, tx_cnt_nx;
  logic [2:0]    tx_idx, tx_idx_nx;
  logic [7:0]    tx_shift, tx_shift_nx;
  logic          tx_nx, tx_bsy_nx;

  rx_state_t     rx_state, rx_state_nx;
  logic [CW-1:0] rx_cnt, rx_cnt_nx;
  logic [2:0]    rx_idx, rx_idx_nx;
  logic [7:0]    rx_data_nx;
  logic          rx_dr_nx;
  logic          rx_meta, rx_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
      tx_bsy   <= 1'b0;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_idx   <= tx_idx_nx;
      tx_shift <= tx_shift_nx;
      tx       <= tx_nx;
      tx_bsy   <= tx_bsy_nx;
    end
  end

  // tx and tx_bsy are registered so the line never glitches between states
  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_idx_nx   = tx_idx;
    tx_shift_nx = tx_shift;
    tx_nx       = tx;
    tx_bsy_nx   = tx_bsy;
    case (tx_state)
      TX_IDLE: begin
        if (tx_go) begin
          tx_state_nx = TX_START;
          tx_shift_nx = tx_data;
          tx_cnt_nx   = '0;
          tx_nx       = 1'b0;
          tx_bsy_nx   = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_nx = TX_DATA;
          tx_cnt_nx   = '0;
          tx_idx_nx   = '0;
          tx_nx       = tx_shift[0];
        end else begin
          tx_cnt_nx = tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nx = '0;
          if (tx_idx == 3'd7) begin
            tx_state_nx = TX_STOP;
            tx_nx       = 1'b1;
          end else begin
            tx_idx_nx   = tx_idx + 1'b1;
            tx_shift_nx = {1'b0, tx_shift[7:1]};
            tx_nx       = tx_shift[1];
          end
        end else begin
          tx_cnt_nx = tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_nx = TX_ACK;
          tx_cnt_nx   = '0;
          tx_bsy_nx   = 1'b0;
        end else begin
          tx_cnt_nx = tx_cnt + 1'b1;
        end
      end
      TX_ACK: begin
        if (!tx_go) tx_state_nx = TX_IDLE;
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_data  <= '0;
      rx_dr    <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_idx   <= rx_idx_nx;
      rx_data  <= rx_data_nx;
      rx_dr    <= rx_dr_nx;
    end
  end

  // Start bit is re-checked at its midpoint; later samples land mid-bit
  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_idx_nx   = rx_idx;
    rx_data_nx  = rx_data;
    rx_dr_nx    = rx_dr;
    case (rx_state)
      RX_IDLE: begin
        if (rx_go && !rx_sync) begin
          rx_state_nx = RX_START;
          rx_cnt_nx   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nx = '0;
          rx_idx_nx = '0;
          rx_state_nx = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_nx = rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nx  = '0;
          rx_data_nx = {rx_sync, rx_data[7:1]};
          if (rx_idx == 3'd7) rx_state_nx = RX_STOP;
          else                rx_idx_nx   = rx_idx + 1'b1;
        end else begin
          rx_cnt_nx = rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nx = '0;
          if (rx_sync) begin
            rx_state_nx = RX_READY;
            rx_dr_nx    = 1'b1;
          end else begin
            rx_state_nx = RX_FERR;
          end
        end else begin
          rx_cnt_nx = rx_cnt + 1'b1;
        end
      end
      RX_FERR: begin
        if (rx_sync) rx_state_nx = RX_IDLE;
      end
      RX_READY: begin
        if (!rx_go) begin
          rx_state_nx = RX_IDLE;
          rx_dr_nx    = 1'b0;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: TX framing/handshake, RX reception,
// glitch and framing-error rejection, loopback and asynchronous reset.
module tb_uart_transceiver;

  localparam int CLK_FREQ  = 1000;
  localparam int BAUD_RATE = 100;
  localparam int BT        = CLK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_go;
  logic       tx;
  logic       tx_bsy;
  logic       rx_line;
  logic       rx_go;
  logic [7:0] rx_data;
  logic       rx_dr;
  logic       rx_drv;
  logic       loop_en;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rx_start_cycle = 0;
  bit lat_valid = 1'b0;
  logic rx_dr_seen;
  logic [7:0] mon_exp;
  int mon_lat;
  int bad;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] loop_bytes[3];

  assign rx_line = loop_en ? tx : rx_drv;

  uart_transceiver #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_go(tx_go), .tx(tx), .tx_bsy(tx_bsy),
    .rx(rx_line), .rx_go(rx_go), .rx_data(rx_data), .rx_dr(rx_dr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every rising rx_dr must match the oldest expected byte
  initial begin
    rx_dr_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_dr === 1'b1 && !rx_dr_seen) begin
        if (rx_q.size() == 0) begin
          checks++;
          errors++;
          $error("[TB] FAIL rx_unexpected observed %0h expected no byte", rx_data);
        end else begin
          mon_exp = rx_q.pop_front();
          checkOutput("rx_data", 32'(rx_data), 32'(mon_exp));
          if (lat_valid) begin
            mon_lat = cyc - rx_start_cycle;
            checks++;
            assert (mon_lat >= 96 && mon_lat <= 100) else begin
              errors++;
              $error("[TB] FAIL rx_latency observed %0d expected 96..100", mon_lat);
            end
            lat_valid = 1'b0;
          end
        end
      end
      rx_dr_seen = (rx_dr === 1'b1);
    end
  end

  task automatic txFrame();
    logic [7:0] exp_b;
    logic [7:0] got;
    logic       exp_line;
    int         bsy_cnt;
    int         line_err;
    int         bit_no;
    got = '0;
    bsy_cnt = 0;
    line_err = 0;
    @(posedge clk); #1;
    checkOutput("tx_bsy_rise", 32'(tx_bsy), 32'd1);
    exp_b = tx_q.pop_front();
    for (int i = 0; i < 10 * BT; i++) begin
      bit_no = i / BT;
      if (bit_no == 0)      exp_line = 1'b0;
      else if (bit_no == 9) exp_line = 1'b1;
      else                  exp_line = exp_b[bit_no-1];
      if (tx !== exp_line) line_err++;
      if (tx_bsy === 1'b1) bsy_cnt++;
      if (i % BT == BT / 2 && bit_no >= 1 && bit_no <= 8) got[bit_no-1] = tx;
      if (i == 25) tx_data = ~tx_data;
      @(posedge clk); #1;
    end
    checkOutput("tx_line_pattern", 32'(line_err), 32'd0);
    checkOutput("tx_bsy_cycles", 32'(bsy_cnt), 32'(10 * BT));
    checkOutput("tx_bsy_fall", 32'(tx_bsy), 32'd0);
    checkOutput("tx_byte", 32'(got), 32'(exp_b));
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_go = 1'b1;
    tx_q.push_back(b);
    txFrame();
    @(negedge clk);
    tx_go = 1'b0;
  endtask

  task automatic rxSendByte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    @(negedge clk);
    rx_start_cycle = cyc;
    lat_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rx_drv = frame[i];
      repeat (BT) @(negedge clk);
    end
  endtask

  task automatic waitRxDr(input string tag);
    int n;
    n = 0;
    while (rx_dr !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(rx_dr), 32'd1);
  endtask

  task automatic ackRx();
    @(negedge clk);
    rx_go = 1'b0;
    @(posedge clk); #1;
    checkOutput("rx_dr_clear", 32'(rx_dr), 32'd0);
    @(negedge clk);
    rx_go = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    tx_go = 1'b0;
    rx_go = 1'b0;
    rx_drv = 1'b1;
    loop_en = 1'b0;
    tx_data = 8'h00;
    loop_bytes = '{8'h00, 8'hFF, 8'h7E};

    #12;
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_tx_bsy", 32'(tx_bsy), 32'd0);
    checkOutput("reset_rx_dr", 32'(rx_dr), 32'd0);
    checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Transmit 0xA5 and keep tx_go high afterwards: no second frame
    @(negedge clk);
    tx_data = 8'hA5;
    tx_go = 1'b1;
    tx_q.push_back(8'hA5);
    txFrame();
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_bsy !== 1'b0 || tx !== 1'b1) bad++;
    end
    checkOutput("tx_no_refire", 32'(bad), 32'd0);
    @(negedge clk);
    tx_go = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(8'h5A);

    // Receive path with direct line drive
    @(negedge clk);
    rx_go = 1'b1;
    repeat (5) @(negedge clk);
    rx_q.push_back(8'h3C);
    rxSendByte(8'h3C, 1'b1);
    waitRxDr("rx_dr_3c");
    checkOutput("rx_hold_3c", 32'(rx_data), 32'h3C);
    ackRx();
    rx_q.push_back(8'hFF);
    rxSendByte(8'hFF, 1'b1);
    waitRxDr("rx_dr_ff");
    ackRx();

    // Short low glitch must be rejected
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("glitch_no_dr", 32'(rx_dr), 32'd0);
    rx_q.push_back(8'h55);
    rxSendByte(8'h55, 1'b1);
    waitRxDr("rx_dr_55");
    ackRx();

    // Framing error followed by a break, then a valid frame
    rxSendByte(8'hA3, 1'b0);
    repeat (30) @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("ferr_no_dr", 32'(rx_dr), 32'd0);
    rx_q.push_back(8'h81);
    rxSendByte(8'h81, 1'b1);
    waitRxDr("rx_dr_81");
    ackRx();

    // Loopback: tx wired into rx
    @(negedge clk);
    loop_en = 1'b1;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rx_q.push_back(loop_bytes[k]);
      applyStimulus(loop_bytes[k]);
      waitRxDr("loop_rx_dr");
      ackRx();
    end
    @(negedge clk);
    rx_go = 1'b0;
    applyStimulus(8'hC3);
    repeat (10) @(negedge clk);
    checkOutput("drop_no_dr", 32'(rx_dr), 32'd0);
    rx_go = 1'b1;
    repeat (5) @(negedge clk);

    // Asynchronous reset in the middle of a loopback frame
    tx_data = 8'h96;
    tx_go = 1'b1;
    repeat (45) @(negedge clk);
    checkOutput("pre_reset_busy", 32'(tx_bsy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_tx", 32'(tx), 32'd1);
    checkOutput("async_reset_tx_bsy", 32'(tx_bsy), 32'd0);
    checkOutput("async_reset_rx_dr", 32'(rx_dr), 32'd0);
    checkOutput("async_reset_rx_data", 32'(rx_data), 32'd0);
    tx_go = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rx_q.push_back(8'h3A);
    applyStimulus(8'h3A);
    waitRxDr("post_reset_rx_dr");
    ackRx();

    repeat (5) @(negedge clk);
    checkOutput("rx_q_drained", 32'(rx_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
